sdram_wb_arbiter: RTL

//  Owns the single Wishbone port into the SDRAM controller and shares it between the CPU core

---
 rtl/archie_mem_pkg.sv | 13 +
 rtl/rom_erase_counter.sv | 17 +
 rtl/sdram_wb_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/archie_mem_pkg.sv
// archie_mem_pkg: shared types for the SDRAM Wishbone arbiter
package archie_mem_pkg;
  typedef enum logic [2:0] {CORE, DRAIN, ERASE, LOAD, LDWR} arb_state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB = 3'b111;
  typedef struct packed {
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [23:0] adr;
    logic [31:0] dat;
  } wb_req_t;
endpackage

// File: rtl/rom_erase_counter.sv
// rom_erase_counter: erase word counter that advances on each acknowledged beat
module rom_erase_counter #(
  parameter int AW = 20
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [AW-1:0] cnt_o,
  output logic          last_o
);
  logic [AW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : adv_i ? cnt_q + AW'(1) : cnt_q;
  always_ff @(posedge clk_sys) cnt_q <= reset ? '0 : cnt_d;
  assign cnt_o = cnt_q;
  assign last_o = &cnt_q;
endmodule

// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: shares the SDRAM Wishbone port between the core and the ROM download path
module sdram_wb_arbiter
  import archie_mem_pkg::*;
#(
  parameter int         ERASE_AW = 20,
  parameter logic [1:0] ROM_PAGE = 2'b01
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        ioctl_wr,
  input  logic [21:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_stall,
  output logic        core_hold,
  input  logic        core_stb,
  input  logic        core_cyc,
  input  logic        core_we,
  input  logic [3:0]  core_sel,
  input  logic [2:0]  core_cti,
  input  logic [21:0] core_adr,
  input  logic [31:0] core_dat_o,
  output logic        core_ack,
  output logic        ram_stb,
  output logic        ram_cyc,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [23:0] ram_adr,
  output logic [31:0] ram_dat,
  input  logic        ram_ack
);
  arb_state_t state_q, state_d;
  logic dl_q, hold_q, stall_q, stall_d;
  logic [20:0] ld_adr_q, ld_adr_d;
  logic [15:0] ld_dat_q, ld_dat_d;
  logic [ERASE_AW-1:0] cnt;
  logic last, ack, dl_rise, drain_done;
  logic unused_addr0;
  wb_req_t core_req, erase_req, ld_req, req;
  assign unused_addr0 = ioctl_addr[0];
  assign ack = ram_ack && ram_stb;
  assign dl_rise = dl_active && !dl_q;
  assign drain_done = (ack && (core_cti == CTI_CLASSIC || core_cti == CTI_EOB)) || !core_cyc;
  rom_erase_counter #(.AW(ERASE_AW)) u_cnt (
    .clk_sys(clk_sys),
    .reset  (reset),
    .clr_i  (state_q != ERASE),
    .adv_i  (state_q == ERASE && ack && dl_active && !last),
    .cnt_o  (cnt),
    .last_o (last)
  );
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    ld_adr_d = ld_adr_q;
    ld_dat_d = ld_dat_q;
    case (state_q)
      CORE: if (dl_rise) begin
        state_d = core_cyc ? DRAIN : ERASE;
        stall_d = 1'b1;
      end
      DRAIN: if (drain_done) begin
        state_d = dl_active ? ERASE : CORE;
        stall_d = dl_active;
      end
      ERASE: if (ack && (last || !dl_active)) begin
        state_d = dl_active ? LOAD : CORE;
        stall_d = 1'b0;
      end
      LOAD: begin
        stall_d = ioctl_wr;
        if (ioctl_wr) begin
          ld_adr_d = ioctl_addr[21:1];
          ld_dat_d = ioctl_dout;
          state_d = LDWR;
        end else if (!dl_active) state_d = CORE;
      end
      LDWR: if (ack) begin
        state_d = dl_active ? LOAD : CORE;
        stall_d = 1'b0;
      end
      default: state_d = CORE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= CORE;
      dl_q <= 1'b0;
      hold_q <= 1'b0;
      stall_q <= 1'b0;
      ld_adr_q <= '0;
      ld_dat_q <= '0;
    end else begin
      state_q <= state_d;
      dl_q <= dl_active;
      hold_q <= state_q != CORE;
      stall_q <= stall_d;
      ld_adr_q <= ld_adr_d;
      ld_dat_q <= ld_dat_d;
    end
  end
  // ram_* depend only on state and registers, never on ram_ack
  assign core_req = '{stb: core_stb, we: core_we, sel: core_sel, adr: {2'b00, core_adr}, dat: core_dat_o};
  assign erase_req = '{stb: 1'b1, we: 1'b1, sel: 4'hf, adr: {ROM_PAGE, 22'(cnt)}, dat: 32'h0};
  assign ld_req = '{stb: 1'b1, we: 1'b1, sel: ld_adr_q[0] ? 4'hc : 4'h3,
                    adr: {ROM_PAGE, 2'b00, ld_adr_q[20:1]}, dat: {ld_dat_q, ld_dat_q}};
  assign req = state_q == ERASE ? erase_req : state_q == LDWR ? ld_req :
               state_q == LOAD ? '0 : core_req;
  assign ram_stb = req.stb;
  assign ram_cyc = req.stb;
  assign ram_we = req.we;
  assign ram_sel = req.sel;
  assign ram_adr = req.adr;
  assign ram_dat = req.dat;
  assign core_ack = ram_ack && (state_q == CORE || state_q == DRAIN);
  assign ioctl_stall = stall_q;
  assign core_hold = state_q != CORE || hold_q;
endmodule
